cc_unit: RTL and testbench

CC_UNIT -- requirements
Module: cc_unit

---
 rtl/cc_unit.sv | 133 +++++++++++++
 tb/tb_cc_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cc_unit.sv
// cc_unit: condition-code register, branch-condition decoder and optional interrupt flag-save stack.
// Build option: define CC_FLAG_STACK_EN to include the flag stack (default build has no stack).
`default_nettype none

module cc_unit #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flag_we,
  input  logic       z_in,
  input  logic       v_in,
  input  logic       c_in,
  input  logic       n_in,
  input  logic [3:0] cond,
  input  logic       push,
  input  logic       pop,
  output logic       z,
  output logic       v,
  output logic       c,
  output logic       n,
  output logic       pre_c,
  output logic       take,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       stack_err
);

  logic [3:0] flags_q;
  logic [3:0] flags_in;
  logic [3:0] restore_val;
  logic       restore;
  logic       freeze;

  assign flags_q  = {z, v, c, n};
  assign flags_in = {z_in, v_in, c_in, n_in};
  assign pre_c    = c;

`ifdef CC_FLAG_STACK_EN
  localparam int SPW = $clog2(DEPTH) + 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  logic [SPW-1:0] sp;
  logic [SPW-1:0] sp_top;
  logic [3:0]     stack_mem [DEPTH];
  logic           do_push;
  logic           bad_push;
  logic           bad_pop;

  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == '0);
  assign sp_top      = sp - 1'b1;

  assign do_push  = push & ~pop & ~stack_full;
  assign bad_push = push & ~pop & stack_full;
  assign restore  = pop & ~push & ~stack_empty;
  assign bad_pop  = pop & ~push & stack_empty;
  assign freeze   = push & pop;

  assign restore_val = stack_mem[sp_top[SPW-2:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      if (do_push) begin
        sp <= sp + 1'b1;
      end else if (restore) begin
        sp <= sp_top;
      end
      if (bad_push || bad_pop) begin
        stack_err <= 1'b1;
      end
    end
  end

  // Entries are only read while occupied, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      stack_mem[sp[SPW-2:0]] <= flags_q;
    end
  end
`else
  logic unused_stack_ctl;

  assign unused_stack_ctl = push | pop;
  assign restore_val      = 4'b0000;
  assign restore          = 1'b0;
  assign freeze           = 1'b0;
  assign stack_full       = 1'b0;
  assign stack_empty      = 1'b1;
  assign stack_err        = 1'b0;
`endif

  // A successful restore wins over a flag write; push+pop together freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {z, v, c, n} <= 4'b0000;
    end else if (freeze) begin
      {z, v, c, n} <= flags_q;
    end else if (restore) begin
      {z, v, c, n} <= restore_val;
    end else if (flag_we) begin
      {z, v, c, n} <= flags_in;
    end
  end

  always_comb begin
    take = 1'b0;
    case (cond)
      4'd0:    take = z;
      4'd1:    take = ~z;
      4'd2:    take = c;
      4'd3:    take = ~c;
      4'd4:    take = n;
      4'd5:    take = ~n;
      4'd6:    take = v;
      4'd7:    take = ~v;
      4'd8:    take = c & ~z;
      4'd9:    take = ~c | z;
      4'd10:   take = ~(n ^ v);
      4'd11:   take = n ^ v;
      4'd12:   take = ~z & ~(n ^ v);
      4'd13:   take = z | (n ^ v);
      4'd14:   take = 1'b1;
      default: take = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cc_unit.sv
// tb_cc_unit: scoreboard bench for cc_unit against a queue-based reference model.
`default_nettype none

module tb_cc_unit;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flag_we = 1'b0;
  logic       z_in = 1'b0, v_in = 1'b0, c_in = 1'b0, n_in = 1'b0;
  logic [3:0] cond = 4'd0;
  logic       push = 1'b0, pop = 1'b0;
  logic       z, v, c, n, pre_c, take, stack_full, stack_empty, stack_err;

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  typedef struct {
    logic [3:0] flags;
    logic       take;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: flags as {z,v,c,n}, stack as a LIFO queue.
  logic [3:0] m_flags = 4'b0000;
  logic [3:0] m_stk[$];
  logic       m_err = 1'b0;

  cc_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
    .z_in(z_in), .v_in(v_in), .c_in(c_in), .n_in(n_in),
    .cond(cond), .push(push), .pop(pop),
    .z(z), .v(v), .c(c), .n(n), .pre_c(pre_c), .take(take),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  function automatic logic take_of(input logic [3:0] cd, input logic [3:0] f);
    logic zz, vv, cc, nn;
    logic [15:0] t;
    zz = f[3]; vv = f[2]; cc = f[1]; nn = f[0];
    t = {1'b0, 1'b1, zz | (nn != vv), !zz && (nn == vv), nn != vv, nn == vv,
         !cc || zz, cc && !zz, !vv, vv, !nn, nn, !cc, cc, !zz, zz};
    return t[cd];
  endfunction

  function automatic logic m_full();
`ifdef CC_FLAG_STACK_EN
    return m_stk.size() == DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_empty();
`ifdef CC_FLAG_STACK_EN
    return m_stk.size() == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_step(input logic r, we, input logic [3:0] f, input logic pu, po);
    if (!r) begin
      m_flags = 4'b0000;
      m_stk.delete();
      m_err = 1'b0;
      return;
    end
`ifdef CC_FLAG_STACK_EN
    if (pu && po) return;
    if (pu) begin
      if (m_stk.size() == DEPTH) m_err = 1'b1;
      else m_stk.push_back(m_flags);
    end
    if (po) begin
      if (m_stk.size() == 0) m_err = 1'b1;
      else begin
        m_flags = m_stk.pop_back();
        return;
      end
    end
`endif
    if (we) m_flags = f;
  endtask

  // One clock of stimulus; expected pre-edge view is queued, then the model advances.
  task automatic cyc(input logic r, we, input logic [3:0] f, input logic [3:0] cd,
                     input logic pu, po);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; flag_we = we; {z_in, v_in, c_in, n_in} = f; cond = cd; push = pu; pop = po;
    e.flags = m_flags;
    e.take  = take_of(cd, m_flags);
    e.full  = m_full();
    e.empty = m_empty();
    e.err   = m_err;
    exp_q.push_back(e);
    model_step(r, we, f, pu, po);
  endtask

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares DUT outputs mid-cycle whenever an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("z", z, e.flags[3]);
        chk("v", v, e.flags[2]);
        chk("c", c, e.flags[1]);
        chk("n", n, e.flags[0]);
        chk("pre_c", pre_c, e.flags[1]);
        chk("take", take, e.take);
        chk("stack_full", stack_full, e.full);
        chk("stack_empty", stack_empty, e.empty);
        chk("stack_err", stack_err, e.err);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    // Reset state and full condition table on reset flags.
    cyc(0, 1, 4'b1111, 4'd0, 1, 0);
    for (int i = 0; i < 16; i++) cyc(1, 0, 4'b0000, i[3:0], 0, 0);
    // Z load: take shows old flags in the write cycle, new ones after.
    cyc(1, 1, 4'b1000, 4'd0, 0, 0);
    cyc(1, 0, 4'b0000, 4'd0, 0, 0);
    cyc(1, 0, 4'b0000, 4'd1, 0, 0);
    // N=1, V=0 signed conditions.
    cyc(1, 1, 4'b0001, 4'd0, 0, 0);
    cyc(1, 0, 4'b0000, 4'd11, 0, 0);
    cyc(1, 0, 4'b0000, 4'd10, 0, 0);
    cyc(1, 0, 4'b0000, 4'd13, 0, 0);
    // Save carry, clobber, restore.
    cyc(1, 1, 4'b0010, 4'd2, 0, 0);
    cyc(1, 0, 4'b0000, 4'd2, 1, 0);
    cyc(1, 1, 4'b0000, 4'd2, 0, 0);
    cyc(1, 0, 4'b0000, 4'd2, 0, 1);
    cyc(1, 0, 4'b0000, 4'd2, 0, 0);
    // Five pushes of distinct flags, then pops in LIFO order plus one underflow.
    for (int i = 0; i < 5; i++) cyc(1, 1, 4'(i + 3), 4'(i), 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 4'b0000, 4'(i + 8), 0, 1);
    // Pop on empty after reset with carry write.
    cyc(0, 0, 4'b0000, 4'd0, 0, 0);
    cyc(1, 1, 4'b0010, 4'd2, 0, 1);
    cyc(1, 0, 4'b0000, 4'd2, 0, 0);
    // Pop overrides flag_we; push+pop is a full no-op.
    cyc(0, 0, 4'b0000, 4'd0, 0, 0);
    cyc(1, 1, 4'b1001, 4'd0, 0, 0);
    cyc(1, 0, 4'b0000, 4'd0, 1, 0);
    cyc(1, 1, 4'b0110, 4'd0, 0, 1);
    cyc(1, 0, 4'b0000, 4'd12, 1, 0);
    cyc(1, 1, 4'b0111, 4'd12, 1, 1);
    cyc(1, 0, 4'b0000, 4'd12, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 49) != 0), $urandom_range(0, 1),
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end
    cyc(1, 0, 4'b0000, 4'd0, 0, 0);
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
    end
  end

endmodule

`default_nettype wire
